// File: rtl/chip_pump_sequencer_if.sv
// Command handshake and pneumatic control bundle between host logic and the pump sequencer.
interface chip_pump_sequencer_if #(
   parameter int unsigned STROKE_W = 8
) ();
   logic                cmd_valid;
   logic                cmd_ready;
   logic [2:0]          cmd_src;
   logic [STROKE_W-1:0] cmd_strokes;
   logic                abort;
   logic [4:0]          ctrl_inlet;
   logic [1:0]          ctrl_prep_outlet;
   logic [2:0]          pump;
   logic                busy;
   logic                done;
   logic                aborted;
   logic                err;
   logic [STROKE_W-1:0] strokes_left;

   modport master (
      output cmd_valid, cmd_src, cmd_strokes, abort,
      input  cmd_ready, ctrl_inlet, ctrl_prep_outlet, pump, busy, done, aborted, err,
             strokes_left
   );

   modport slave (
      input  cmd_valid, cmd_src, cmd_strokes, abort,
      output cmd_ready, ctrl_inlet, ctrl_prep_outlet, pump, busy, done, aborted, err,
             strokes_left
   );
endinterface

// File: rtl/chip_pump_sequencer.sv
// Sequences one prep-path transfer: open inlet/outlet valves, run the peristaltic pump for N
// strokes, then vent and close. Pneumatic outputs: 1 = pressurized (closed), 0 = vented (open).
module chip_pump_sequencer #(
   parameter int unsigned PHASE_CYCLES  = 16,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned STROKE_W      = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   chip_pump_sequencer_if.slave  bus
);

   localparam int unsigned MAX_HOLD = (PHASE_CYCLES > SETTLE_CYCLES) ? PHASE_CYCLES
                                                                     : SETTLE_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(PHASE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StOpen, StPump, StClose, StDone} state_e;

   state_e              state;
   logic [CNT_W-1:0]    hold_cnt;
   logic [2:0]          pat_idx;
   logic                abort_flag;
   logic [4:0]          ctrl_inlet;
   logic [1:0]          ctrl_prep_outlet;
   logic [2:0]          pump;
   logic                cmd_ready;
   logic                busy;
   logic                done;
   logic                aborted;
   logic                err;
   logic [STROKE_W-1:0] strokes_left;
   logic                cmd_legal;
   logic                abort_hit;

   // Peristaltic sequence; only one chamber changes per step and 000 never appears.
   function automatic logic [2:0] pump_pattern(input logic [2:0] idx);
      case (idx)
         3'd0:    pump_pattern = 3'b101;
         3'd1:    pump_pattern = 3'b100;
         3'd2:    pump_pattern = 3'b110;
         3'd3:    pump_pattern = 3'b010;
         3'd4:    pump_pattern = 3'b011;
         3'd5:    pump_pattern = 3'b001;
         default: pump_pattern = 3'b111;
      endcase
   endfunction

   assign cmd_legal = (bus.cmd_src <= 3'd4) && (bus.cmd_strokes != '0);
   assign abort_hit = bus.abort && ((state == StOpen) || (state == StPump));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= StIdle;
         hold_cnt         <= '0;
         pat_idx          <= '0;
         abort_flag       <= 1'b0;
         ctrl_inlet       <= 5'b11111;
         ctrl_prep_outlet <= 2'b11;
         pump             <= 3'b111;
         cmd_ready        <= 1'b1;
         busy             <= 1'b0;
         done             <= 1'b0;
         aborted          <= 1'b0;
         err              <= 1'b0;
         strokes_left     <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         err     <= 1'b0;
         if (abort_hit) begin
            // Abort beats settle/phase completion; strokes_left is left frozen.
            state      <= StClose;
            hold_cnt   <= '0;
            abort_flag <= 1'b1;
            pump       <= 3'b111;
            ctrl_inlet <= 5'b11111;
         end else begin
            case (state)
               StIdle: begin
                  if (bus.cmd_valid) begin
                     if (cmd_legal) begin
                        state            <= StOpen;
                        hold_cnt         <= '0;
                        strokes_left     <= bus.cmd_strokes;
                        ctrl_inlet       <= ~(5'b00001 << bus.cmd_src);
                        ctrl_prep_outlet <= 2'b00;
                        cmd_ready        <= 1'b0;
                        busy             <= 1'b1;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               StOpen: begin
                  if (hold_cnt == SETTLE_LAST) begin
                     state    <= StPump;
                     hold_cnt <= '0;
                     pat_idx  <= '0;
                     pump     <= pump_pattern(3'd0);
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               StPump: begin
                  if (hold_cnt == PHASE_LAST) begin
                     hold_cnt <= '0;
                     if (pat_idx == 3'd5) begin
                        strokes_left <= strokes_left - 1'b1;
                        if (strokes_left == STROKE_W'(1)) begin
                           state      <= StClose;
                           pump       <= 3'b111;
                           ctrl_inlet <= 5'b11111;
                        end else begin
                           pat_idx <= '0;
                           pump    <= pump_pattern(3'd0);
                        end
                     end else begin
                        pat_idx <= pat_idx + 3'd1;
                        pump    <= pump_pattern(pat_idx + 3'd1);
                     end
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               StClose: begin
                  if (hold_cnt == SETTLE_LAST) begin
                     state            <= StDone;
                     hold_cnt         <= '0;
                     ctrl_prep_outlet <= 2'b11;
                     done             <= 1'b1;
                     aborted          <= abort_flag;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               StDone: begin
                  state      <= StIdle;
                  abort_flag <= 1'b0;
                  cmd_ready  <= 1'b1;
                  busy       <= 1'b0;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

   assign bus.ctrl_inlet       = ctrl_inlet;
   assign bus.ctrl_prep_outlet = ctrl_prep_outlet;
   assign bus.pump             = pump;
   assign bus.cmd_ready        = cmd_ready;
   assign bus.busy             = busy;
   assign bus.done             = done;
   assign bus.aborted          = aborted;
   assign bus.err              = err;
   assign bus.strokes_left     = strokes_left;

endmodule

// File: doc/chip_pump_sequencer.md
# chip_pump_sequencer

Sequences one fluid transfer on the ChIP chip's prep path: opens one of the five prep-inlet control valves and the prep-outlet valves, runs the three-valve peristaltic pump for a commanded number of strokes, then closes everything. It sits between the host command logic and the `pad_ctrl_inlet`, `pad_ctrl_prep_outlet` and `pad_pump` control pads. All control outputs are pneumatic: 1 = pressurized (valve closed), 0 = vented (valve open).

## Interface
- `PHASE_CYCLES`, default 16: clock cycles each pump pattern is held; ≥1.
- `SETTLE_CYCLES`, default 8: valve settle time in the OPEN and CLOSE states; ≥1.
- `STROKE_W`, default 8: width of the stroke count.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: sequencer can accept a command (IDLE only).
- `cmd_src` in 3: prep inlet index, 0–4 legal.
- `cmd_strokes` in STROKE_W: pump strokes, 0 illegal.
- `abort` in 1: level; ends the transfer early, through the CLOSE state.
- `ctrl_inlet` out 5: drives `pad_ctrl_inlet`.
- `ctrl_prep_outlet` out 2: drives `pad_ctrl_prep_outlet`; both bits move together.
- `pump` out 3: drives `pad_pump`.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when a transfer finishes.
- `aborted` out 1: qualifies `done`; high only in the cycle `done` is high, and only if an abort caused the finish.
- `err` out 1: one-cycle pulse when an illegal command is rejected.
- `strokes_left` out STROKE_W: strokes still to run, including the one in progress.

## Operation
- All outputs are registered.
- Reset values: `ctrl_inlet`=5'b11111, `ctrl_prep_outlet`=2'b11, `pump`=3'b111, `cmd_ready`=1, `busy`=0, `done`=0, `aborted`=0, `err`=0, `strokes_left`=0, state IDLE.
- **IDLE**
  - All valves closed; `cmd_ready`=1.
  - A handshake (`cmd_valid`&&`cmd_ready`) with `cmd_src`≥5 or `cmd_strokes`==0 pulses `err` next cycle and stays in IDLE.
  - A legal handshake latches `src` and `strokes_left` and goes to OPEN.
- **OPEN**
  - `ctrl_inlet[src]`=0 and `ctrl_prep_outlet`=2'b00; all other valves stay closed.
  - Held for SETTLE_CYCLES, then go to PUMP with the pattern index at 0.
- **PUMP**
  - Valves stay as in OPEN.
  - `pump` steps through six patterns: 101, 100, 110, 010, 011, 001. Each pattern is held PHASE_CYCLES.
  - After pattern 5 completes, `strokes_left` decrements. If the new value is 0, go to CLOSE; otherwise restart at pattern 0.
- **CLOSE**
  - `pump`=111 and `ctrl_inlet`=all 1; `ctrl_prep_outlet` stays 00 so pressure vents.
  - Held for SETTLE_CYCLES, then go to DONE.
- **DONE**
  - Lasts one cycle: `ctrl_prep_outlet`=11, `done`=1, `aborted`=latched abort flag.
  - Next state IDLE; the abort flag clears.
- **Abort**
  - `abort` sampled high in OPEN or PUMP moves the state to CLOSE on the next edge and sets the abort flag.
  - `strokes_left` freezes at its current value.
  - Abort is ignored in IDLE, CLOSE and DONE.
- **Safety invariants**
  - At most one `ctrl_inlet` bit is 0 at any time.
  - `pump`≠111 only in PUMP.
  - `pump` never shows all-zero.

## Timing
- Handshake at edge T: OPEN outputs are visible after T+1.
- `cmd_ready` drops in the same cycle the state leaves IDLE.
- Legal command, no abort, N strokes: `done` is high in cycle T+1+SETTLE+6·PHASE·N+SETTLE, counting the first OPEN cycle as T+1.
- `cmd_ready` returns to 1 the cycle after `done`. Back-to-back commands therefore have exactly one IDLE cycle between them.
- `strokes_left` updates in the last cycle of pattern 5. Hold counters are STROKE-independent and wrap-free: they are reset on every pattern or state entry.
- Abort and stroke exhaustion in the same cycle: abort wins and `aborted`=1.
- `cmd_valid` while busy is ignored; the command must be held until `cmd_ready`.
- `rst_n` low mid-transfer: all outputs immediately take their reset values (asynchronous), with no `done` pulse.

## Test plan
1. PHASE=4, SETTLE=3; command src=2, strokes=2 → `ctrl_inlet`=11011 for 3+48+0 cycles; pump patterns 101,100,110,010,011,001 each for 4 cycles, twice; `done`=1 with `aborted`=0 exactly 55 cycles after the handshake; all valves back to 1.
2. Command src=5, then src=0 with strokes=0 → `err` pulses once each; `busy` stays 0; valves stay unchanged.
3. Command src=4, strokes=3; assert `abort` during the second pattern of stroke 2 → next cycle `pump`=111 and `ctrl_inlet`=11111; `strokes_left`=2 frozen; `done`=1 with `aborted`=1 after 3 CLOSE cycles.
4. Two back-to-back commands (src=1, then src=3, with `cmd_valid` held) → second handshake occurs one cycle after the first `done`; no cycle ever has two inlet bits at 0.
5. Drive `rst_n` low mid-PUMP → outputs reset asynchronously with no `done`; after release, `cmd_ready`=1 and a fresh command completes normally.
6. Assert `abort` and let the final stroke complete in the same cycle → `aborted`=1.
